result_collector_fifo: RTL and testbench
========================================

// Module: result_collector_fifo
// PURPOSE
//  Receiving end of the STB/BUSY result handshake driven by operation1 (op1_output_STB/output_result).
//  Buffers finished 32-bit results in a DEPTH-entry FIFO, so the compute engine never stalls on a slow consumer.
//  Re-presents buffered results on an identical STB/BUSY source port toward the RoCC response path.
// PARAMETERS
//  WIDTH   32   data width of each result word
//  DEPTH   4    FIFO entries; power of 2, >= 2; pointers are $clog2(DEPTH) bits, count is $clog2(DEPTH)+1 bits
// PORTS
//  clk                 in   1      rising-edge clock
//  rst                 in   1      asynchronous reset, active-high
//  input_result        in   WIDTH  result word from producer (operation1 output_result)
//  input_STB           in   1      producer strobe: input_result valid
//  collector_BUSY      out  1      to producer's output_module_BUSY; high = cannot accept
//  output_result       out  WIDTH  head-of-FIFO word
//  collector_output_STB out 1      head word valid
//  output_module_BUSY  in   1      downstream busy; high = do not pop
//  fill_level          out  $clog2(DEPTH)+1  entries held (only with COLLECTOR_STATS_EN)
//  xfer_count          out  16     accepted words, saturating (only with COLLECTOR_STATS_EN)
// BEHAVIOUR
//  - Handshake rule on both ports: a word transfers on the rising edge where STB=1 and BUSY=0.
//  - Push = input_STB && !collector_BUSY. Pop = collector_output_STB && !output_module_BUSY.
//  - Reset (async, any time, including mid-transfer): wr_ptr=0, rd_ptr=0, count=0, collector_BUSY=0,
//    collector_output_STB=0, output_result=0, fill_level=0, xfer_count=0. Storage RAM is not reset.
//    A transfer on the edge coincident with reset release is not taken.
//  - collector_BUSY = (count == DEPTH), decoded from registered count; no combinational path from input_STB.
//  - collector_output_STB = (count != 0); output_result = mem[rd_ptr] (registered storage, mux read).
//  - Latency: word pushed at edge N is presented with collector_output_STB=1 after edge N (cycle N+1) when
//    FIFO was empty; no fall-through in the same cycle.
//  - Count update: push only -> +1; pop only -> -1; push and pop same edge -> unchanged, both pointers advance.
//  - Full: collector_BUSY=1, push blocked even if pop occurs this edge (BUSY is registered state); deasserts
//    the cycle after the first pop. Words presented while full are held by producer, never dropped.
//  - Empty: pop impossible (STB=0); output_module_BUSY ignored.
//  - Pointers wrap modulo DEPTH (DEPTH-1 -> 0) with no gap.
//  - Order strictly FIFO; data unmodified, WIDTH bits passthrough.
//  - Producer contract: input_result stable while input_STB=1 and collector_BUSY=1.
//  - Control: two-state FSM per port is not required; behaviour is fully defined by count/pointers.
//    Internal states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH);
//    EMPTY->PARTIAL on push; PARTIAL->FULL on push-only at count=DEPTH-1; FULL->PARTIAL on pop;
//    PARTIAL->EMPTY on pop-only at count=1.
// CONFIGURATION
//  COLLECTOR_STATS_EN defined: fill_level and xfer_count ports exist. fill_level = count. xfer_count
//    increments on every push, saturates at 16'hFFFF, cleared only by rst.
//  COLLECTOR_STATS_EN undefined: both ports and their logic are absent; all other behaviour identical.
// TESTING
//  1 Reset: assert rst mid-stream with 3 words held -> all outputs 0 immediately (async), FIFO empty after release.
//  2 Single word: push 32'h3F800000, output_module_BUSY=0 -> collector_output_STB high next cycle with same
//    value, popped on following edge, STB low afterward.
//  3 Fill: DEPTH=4, output_module_BUSY=1, push 0x1..0x5 -> collector_BUSY=1 after 4th push; 5th held by
//    producer; release -> output order 0x1,0x2,0x3,0x4,0x5.
//  4 Simultaneous: count=2, push and pop same edge -> count stays 2, fill_level=2, order preserved.
//  5 Wrap: stream 10 words with random output_module_BUSY -> pointers wrap twice, no loss/duplication.
//  6 Stats (COLLECTOR_STATS_EN): 70000 pushes -> xfer_count=16'hFFFF (saturated); without macro, build has
//    no fill_level/xfer_count ports.

Source files
------------

// File: rtl/result_collector_fifo.sv
// ----------------------------------------------------------------------------
// result_collector_fifo
//   This module is the receiving end of the STB/BUSY result handshake that
//   operation1 drives. It buffers finished result words in a DEPTH-entry FIFO,
//   so the compute engine does not stall when the consumer is slow. It then
//   presents the buffered words again on an identical STB/BUSY source port
//   toward the RoCC response path.
//
//   A word transfers on a rising edge where STB=1 and BUSY=0. This rule
//   applies on both ports.
//
// Parameters
//   WIDTH  data width of each result word (default 32)
//   DEPTH  FIFO entries, must be a power of 2 and at least 2 (default 4)
//
// Ports
//   clk                   in   rising-edge clock
//   rst                   in   asynchronous reset, active-high
//   input_result          in   result word from the producer
//   input_STB             in   producer strobe, input_result is valid
//   collector_BUSY        out  high = the FIFO is full and cannot accept
//   output_result         out  head-of-FIFO word (0 when empty)
//   collector_output_STB  out  head word is valid
//   output_module_BUSY    in   downstream busy, high = do not pop
//   fill_level            out  number of entries held    (COLLECTOR_STATS_EN only)
//   xfer_count            out  accepted words, saturating (COLLECTOR_STATS_EN only)
//
// Configuration
//   The macro COLLECTOR_STATS_EN adds the fill_level and xfer_count ports
//   and their logic. When the macro is not defined, these ports do not exist.
// ----------------------------------------------------------------------------
module result_collector_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           input_result,
    input  logic                       input_STB,
    output logic                       collector_BUSY,
    output logic [WIDTH-1:0]           output_result,
    output logic                       collector_output_STB,
    input  logic                       output_module_BUSY
`ifdef COLLECTOR_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [15:0]                xfer_count
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    // The handshake qualifiers depend only on registered BUSY and STB, so
    // there is no combinational path from input_STB to collector_BUSY.
    assign w_push = input_STB && !collector_BUSY;
    assign w_pop  = collector_output_STB && !output_module_BUSY;

    // Occupancy update. When a push and a pop happen together, the count
    // stays the same.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. FULL can only be left by a pop, because a push is
    // blocked while BUSY is high.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = S_PARTIAL;
                end
            end
            S_PARTIAL: begin
                if (w_push && !w_pop && (r_count == CW'(DEPTH - 1))) begin
                    w_state_nxt = S_FULL;
                end else if (w_pop && !w_push && (r_count == CW'(1))) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt = S_PARTIAL;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Output decode from registered state. The head word is forced to 0 when
    // the FIFO is empty, because the storage itself is never reset.
    always_comb begin
        collector_BUSY       = 1'b0;
        collector_output_STB = 1'b0;
        output_result        = '0;
        case (r_state)
            S_PARTIAL: begin
                collector_output_STB = 1'b1;
                output_result        = r_mem[r_rd_ptr];
            end
            S_FULL: begin
                collector_BUSY       = 1'b1;
                collector_output_STB = 1'b1;
                output_result        = r_mem[r_rd_ptr];
            end
            default: begin
                collector_BUSY       = 1'b0;
                collector_output_STB = 1'b0;
                output_result        = '0;
            end
        endcase
    end

    // Pointers and count. DEPTH is a power of 2, so the pointers wrap
    // naturally from DEPTH-1 back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Storage array, written only on an accepted push and never reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= input_result;
        end
    end

`ifdef COLLECTOR_STATS_EN
    logic [15:0] r_xfer_count;

    // Count of accepted words. It holds at all-ones once it saturates and is
    // cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (w_push && (r_xfer_count != 16'hFFFF)) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign fill_level = r_count;
    assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_result_collector_fifo.sv
// ----------------------------------------------------------------------------
// tb_result_collector_fifo
//   Directed testbench for result_collector_fifo with DEPTH=4 and WIDTH=32.
//   A passive monitor logs every word that crosses either handshake port.
//   The directed sequences compare the outputs and the logged streams against
//   expected values computed by hand.
// ----------------------------------------------------------------------------
module tb_result_collector_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] input_result;
    logic        input_STB;
    logic        collector_BUSY;
    logic [31:0] output_result;
    logic        collector_output_STB;
    logic        output_module_BUSY;
`ifdef COLLECTOR_STATS_EN
    logic [2:0]  fill_level;
    logic [15:0] xfer_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] sent[$];
    logic [31:0] got[$];

    result_collector_fifo #(.WIDTH(32), .DEPTH(4)) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .input_result         (input_result),
        .input_STB            (input_STB),
        .collector_BUSY       (collector_BUSY),
        .output_result        (output_result),
        .collector_output_STB (collector_output_STB),
        .output_module_BUSY   (output_module_BUSY)
`ifdef COLLECTOR_STATS_EN
        ,
        .fill_level           (fill_level),
        .xfer_count           (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log the transfers that occur on each port at each edge
    always @(posedge clk) begin
        if (!rst) begin
            if (input_STB && !collector_BUSY) begin
                sent.push_back(input_result);
            end
            if (collector_output_STB && !output_module_BUSY) begin
                got.push_back(output_result);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold one word on the producer port until it is accepted. The task is
    // called at posedge+1 and returns at posedge+1.
    task automatic send(input logic [31:0] w);
        int  n    = 0;
        bit  done = 1'b0;
        input_result = w;
        input_STB    = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            done = !collector_BUSY;
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            check("send_timeout", {31'b0, collector_BUSY}, 32'h0);
        end
        input_STB = 1'b0;
    endtask

    // Open the consumer and wait a bounded time for the FIFO to empty
    task automatic drain();
        int n = 0;
        output_module_BUSY = 1'b0;
        while (collector_output_STB && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", {31'b0, collector_output_STB}, 32'h0);
    endtask

    initial begin
        rst                = 1'b1;
        input_result       = '0;
        input_STB          = 1'b0;
        output_module_BUSY = 1'b0;

        // ---- 1: reset state, then async reset with 3 words held ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stb",  {31'b0, collector_output_STB}, 32'h0);
        check("rst_busy", {31'b0, collector_BUSY}, 32'h0);
        check("rst_data", output_result, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        output_module_BUSY = 1'b1;
        send(32'h0000_00A1);
        send(32'h0000_00A2);
        send(32'h0000_00A3);
        check("held3_stb",  {31'b0, collector_output_STB}, 32'h1);
        check("held3_head", output_result, 32'h0000_00A1);
`ifdef COLLECTOR_STATS_EN
        check("held3_fill", {29'b0, fill_level}, 32'h3);
`endif
        #3;
        rst = 1'b1;
        #1;
        check("async_stb",  {31'b0, collector_output_STB}, 32'h0);
        check("async_busy", {31'b0, collector_BUSY}, 32'h0);
        check("async_data", output_result, 32'h0);
`ifdef COLLECTOR_STATS_EN
        check("async_fill", {29'b0, fill_level}, 32'h0);
        check("async_xfer", {16'b0, xfer_count}, 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        output_module_BUSY = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_stb", {31'b0, collector_output_STB}, 32'h0);

        // ---- 2: single word latency ----
        sent.delete();
        got.delete();
        input_result = 32'h3F80_0000;
        input_STB    = 1'b1;
        @(posedge clk);
        #1;
        input_STB = 1'b0;
        check("single_stb",  {31'b0, collector_output_STB}, 32'h1);
        check("single_data", output_result, 32'h3F80_0000);
        check("single_nopop", got.size(), 32'd0);
        @(posedge clk);
        #1;
        check("single_stb_low", {31'b0, collector_output_STB}, 32'h0);
        check("single_popped", got.size(), 32'd1);
        if (got.size() == 1) check("single_word", got[0], 32'h3F80_0000);

        // ---- 3: fill to full, fifth word held, release ----
        sent.delete();
        got.delete();
        output_module_BUSY = 1'b1;
        send(32'h1);
        send(32'h2);
        send(32'h3);
        check("fill3_busy", {31'b0, collector_BUSY}, 32'h0);
        send(32'h4);
        check("full_busy", {31'b0, collector_BUSY}, 32'h1);
        fork
            send(32'h5);
            begin
                repeat (2) @(posedge clk);
                #1;
                check("full_hold_busy", {31'b0, collector_BUSY}, 32'h1);
                check("full_head", output_result, 32'h1);
                check("full_5_blocked", sent.size(), 32'd4);
                output_module_BUSY = 1'b0;
                @(posedge clk);
                #1;
                check("first_pop_busy", {31'b0, collector_BUSY}, 32'h0);
                check("pop_edge_no_push", sent.size(), 32'd4);
                check("pop_edge_got", got.size(), 32'd1);
            end
        join
        drain();
        check("fill_order_n", got.size(), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            check($sformatf("fill_order_%0d", i), got[i], 32'(i + 1));
        end

        // ---- 4: simultaneous push and pop at count=2 ----
        sent.delete();
        got.delete();
        output_module_BUSY = 1'b1;
        send(32'hAAAA_0001);
        send(32'hAAAA_0002);
        input_result       = 32'hAAAA_0003;
        input_STB          = 1'b1;
        output_module_BUSY = 1'b0;
        @(posedge clk);
        #1;
        input_STB = 1'b0;
        output_module_BUSY = 1'b1;
        check("simul_head", output_result, 32'hAAAA_0002);
        check("simul_busy", {31'b0, collector_BUSY}, 32'h0);
        check("simul_sent", sent.size(), 32'd3);
        check("simul_got",  got.size(), 32'd1);
`ifdef COLLECTOR_STATS_EN
        check("simul_fill", {29'b0, fill_level}, 32'h2);
`endif
        drain();
        check("simul_n", got.size(), 32'd3);
        if (got.size() == 3) begin
            check("simul_o0", got[0], 32'hAAAA_0001);
            check("simul_o1", got[1], 32'hAAAA_0002);
            check("simul_o2", got[2], 32'hAAAA_0003);
        end

        // ---- 5: ten words, random backpressure, pointers wrap twice ----
        sent.delete();
        got.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(32'hC0DE_0000 | 32'(i));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    output_module_BUSY = 1'($urandom_range(0, 1));
                end
                output_module_BUSY = 1'b0;
            end
        join
        drain();
        check("wrap_n", got.size(), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            check($sformatf("wrap_%0d", i), got[i], 32'hC0DE_0000 | 32'(i));
        end

`ifdef COLLECTOR_STATS_EN
        // ---- 6: transfer counter saturation ----
        // 1 + 5 + 3 + 10 words have been accepted since reset
        check("xfer_19", {16'b0, xfer_count}, 32'd19);
        check("fill_0",  {29'b0, fill_level}, 32'h0);
        output_module_BUSY = 1'b0;
        input_result       = 32'h5555_5555;
        input_STB          = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        input_STB = 1'b0;
        check("xfer_sat", {16'b0, xfer_count}, 32'h0000_FFFF);
        drain();
        sent.delete();
        got.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
